// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the two-port data memory arbiter: FSM encoding,
// port indices and default bus widths.
package data_mem_arbiter_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StServe = 1'b1
  } arb_state_e;

  localparam logic PortCore = 1'b0;
  localparam logic PortDma  = 1'b1;

  localparam int unsigned DefaultAddrWidth = 32;
  localparam int unsigned DefaultDataWidth = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: on a tie the port that did not win last time is granted.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic       grant_o
);

  always_comb begin
    grant_o = 1'b0;
    if (req_i == 2'b11) begin
      grant_o = ~last_owner_i;
    end else if (req_i[1]) begin
      grant_o = 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates core (p0) and DMA (p1) word accesses onto a single data memory port;
// each granted access occupies one SERVE cycle after the grant.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BUS_WIDTH = DefaultAddrWidth,
  parameter int unsigned DATA_BUS_WIDTH = DefaultDataWidth,
  parameter int unsigned MEM_BYTES      = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      p0_req,
  input  logic                      p0_we,
  input  logic [ADDR_BUS_WIDTH-1:0] p0_addr,
  input  logic [DATA_BUS_WIDTH-1:0] p0_wdata,
  output logic                      p0_ack,
  output logic                      p0_err,
  output logic [DATA_BUS_WIDTH-1:0] p0_rdata,
  input  logic                      p1_req,
  input  logic                      p1_we,
  input  logic [ADDR_BUS_WIDTH-1:0] p1_addr,
  input  logic [DATA_BUS_WIDTH-1:0] p1_wdata,
  output logic                      p1_ack,
  output logic                      p1_err,
  output logic [DATA_BUS_WIDTH-1:0] p1_rdata,
  output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
  output logic [DATA_BUS_WIDTH-1:0] mem_write_data,
  output logic                      mem_write_en,
  input  logic [DATA_BUS_WIDTH-1:0] mem_read_data
);

  localparam logic [ADDR_BUS_WIDTH-1:0] MaxAddr = ADDR_BUS_WIDTH'(MEM_BYTES - 4);

  arb_state_e                state_q, state_d;
  logic                      owner_q, owner_d;
  logic                      last_owner_q, last_owner_d;
  logic                      we_q, we_d;
  logic [ADDR_BUS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_BUS_WIDTH-1:0] wdata_q, wdata_d;

  logic grant;
  logic legal;
  logic serve;

  rr_arbiter2 u_rr_arbiter2 (
    .req_i        ({p1_req, p0_req}),
    .last_owner_i (last_owner_q),
    .grant_o      (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= PortCore;
      last_owner_q <= PortDma;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (p0_req || p1_req) begin
          state_d      = StServe;
          owner_d      = grant;
          last_owner_d = grant;
          if (grant == PortDma) begin
            we_d    = p1_we;
            addr_d  = p1_addr;
            wdata_d = p1_wdata;
          end else begin
            we_d    = p0_we;
            addr_d  = p0_addr;
            wdata_d = p0_wdata;
          end
        end
      end
      StServe: state_d = StIdle;
    endcase
  end

  assign legal = (addr_q[1:0] == 2'b00) && (addr_q <= MaxAddr);
  // Reset gates the outputs directly so an access caught by reset never acks.
  assign serve = (state_q == StServe) && !reset;

  always_comb begin
    p0_ack         = 1'b0;
    p0_err         = 1'b0;
    p0_rdata       = '0;
    p1_ack         = 1'b0;
    p1_err         = 1'b0;
    p1_rdata       = '0;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_write_en   = 1'b0;
    if (serve) begin
      mem_addr       = addr_q;
      mem_write_data = wdata_q;
      mem_write_en   = we_q && legal;
      if (owner_q == PortDma) begin
        p1_ack   = 1'b1;
        p1_err   = ~legal;
        p1_rdata = (legal && !we_q) ? mem_read_data : '0;
      end else begin
        p0_ack   = 1'b1;
        p0_err   = ~legal;
        p0_rdata = (legal && !we_q) ? mem_read_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a behavioural big-endian 64-byte data memory.
module tb_data_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 64;

  logic          clk;
  logic          reset;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_ack, p0_err, p1_ack, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_en;
  logic [DW-1:0] mem_read_data;

  data_mem_arbiter #(
    .ADDR_BUS_WIDTH (AW),
    .DATA_BUS_WIDTH (DW),
    .MEM_BYTES      (MB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .p0_req         (p0_req),
    .p0_we          (p0_we),
    .p0_addr        (p0_addr),
    .p0_wdata       (p0_wdata),
    .p0_ack         (p0_ack),
    .p0_err         (p0_err),
    .p0_rdata       (p0_rdata),
    .p1_req         (p1_req),
    .p1_we          (p1_we),
    .p1_addr        (p1_addr),
    .p1_wdata       (p1_wdata),
    .p1_ack         (p1_ack),
    .p1_err         (p1_err),
    .p1_rdata       (p1_rdata),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data)
  );

  // Data memory: combinational big-endian read, store on falling edge.
  logic [7:0] mem [MB];
  logic [5:0] ma;
  assign ma = mem_addr[5:0];
  assign mem_read_data = {mem[ma], mem[ma + 6'd1], mem[ma + 6'd2], mem[ma + 6'd3]};

  always @(negedge clk) begin
    if (mem_write_en) begin
      mem[ma]        <= mem_write_data[31:24];
      mem[ma + 6'd1] <= mem_write_data[23:16];
      mem[ma + 6'd2] <= mem_write_data[15:8];
      mem[ma + 6'd3] <= mem_write_data[7:0];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   we_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ack(input logic port, input logic err, input logic [31:0] rdata,
                            input int c);
    exp_t e;
    e.port  = port;
    e.err   = err;
    e.rdata = rdata;
    e.cyc   = c;
    sb_q.push_back(e);
  endtask

  // Monitor: pops one expectation per observed ack.
  always @(negedge clk) begin
    exp_t e;
    if (mem_write_en) begin
      we_count++;
      check("write_addr_legal", {31'd0, (mem_addr[1:0] == 2'b00) && (mem_addr <= 32'(MB - 4))},
            32'd1);
    end
    if (p0_ack && p1_ack) check("dual_ack", 32'd1, 32'd0);
    else if (p0_ack || p1_ack) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack_port", {31'd0, p1_ack}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("ack_port", {31'd0, p1_ack}, {31'd0, e.port});
        check("ack_err", {31'd0, p1_ack ? p1_err : p0_err}, {31'd0, e.err});
        check("ack_rdata", p1_ack ? p1_rdata : p0_rdata, e.rdata);
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_acks"}, {30'd0, p1_ack, p0_ack}, 32'd0);
    check({name, "_errs"}, {30'd0, p1_err, p0_err}, 32'd0);
    check({name, "_rdata"}, p0_rdata | p1_rdata, 32'd0);
    check({name, "_mem_we"}, {31'd0, mem_write_en}, 32'd0);
    check({name, "_mem_addr"}, mem_addr, 32'd0);
    check({name, "_mem_wdata"}, mem_write_data, 32'd0);
  endtask

  task automatic run_p0(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    logic got;
    got = 1'b0;
    p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (p0_ack) begin
        got = 1'b1;
        break;
      end
    end
    p0_req = 1'b0;
    if (!got) check("p0_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_p1(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    logic got;
    got = 1'b0;
    p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (p1_ack) begin
        got = 1'b1;
        break;
      end
    end
    p1_req = 1'b0;
    if (!got) check("p1_ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int c;
    int wc;
    for (int i = 0; i < int'(MB); i++) mem[i] = 8'(i);
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h0A;
    reset = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;

    @(posedge clk);
    @(negedge clk);
    check_quiet("in_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_quiet("after_reset");
    step();

    // Single p0 store then load back
    c = cyc;
    wc = we_count;
    expect_ack(1'b0, 1'b0, 32'h0, c + 1);
    run_p0(1'b1, 32'h08, 32'hDEAD_BEEF);
    step();
    check("store_write_count", 32'(we_count - wc), 32'd1);
    c = cyc;
    expect_ack(1'b0, 1'b0, 32'hDEAD_BEEF, c + 1);
    run_p0(1'b0, 32'h08, 32'h0);
    step();

    // Simultaneous requests straight after reset: p0 wins the first tie
    reset = 1'b1;
    step();
    reset = 1'b0;
    c = cyc;
    expect_ack(1'b0, 1'b0, 32'h0000_000A, c + 1);
    expect_ack(1'b1, 1'b0, 32'h0405_0607, c + 3);
    fork
      run_p0(1'b0, 32'h00, 32'h0);
      run_p1(1'b0, 32'h04, 32'h0);
    join
    step();

    // Both held for 8 cycles: strict alternation
    c = cyc;
    expect_ack(1'b0, 1'b0, 32'hDEAD_BEEF, c + 1);
    expect_ack(1'b1, 1'b0, 32'h0C0D_0E0F, c + 3);
    expect_ack(1'b0, 1'b0, 32'hDEAD_BEEF, c + 5);
    expect_ack(1'b1, 1'b0, 32'h0C0D_0E0F, c + 7);
    p0_we = 1'b0; p0_addr = 32'h08;
    p1_we = 1'b0; p1_addr = 32'h0C;
    p0_req = 1'b1; p1_req = 1'b1;
    repeat (8) step();
    p0_req = 1'b0; p1_req = 1'b0;
    step();

    // Illegal stores: misaligned and past end of memory
    wc = we_count;
    c = cyc;
    expect_ack(1'b1, 1'b1, 32'h0, c + 1);
    run_p1(1'b1, 32'h3E, 32'h1122_3344);
    step();
    c = cyc;
    expect_ack(1'b1, 1'b1, 32'h0, c + 1);
    run_p1(1'b1, 32'h40, 32'h5566_7788);
    step();
    check("illegal_store_we", 32'(we_count - wc), 32'd0);
    check("mem_3c_3f", {mem[60], mem[61], mem[62], mem[63]}, 32'h3C3D_3E3F);
    c = cyc;
    expect_ack(1'b1, 1'b0, 32'h3C3D_3E3F, c + 1);
    run_p1(1'b0, 32'h3C, 32'h0);
    step();
    c = cyc;
    expect_ack(1'b0, 1'b1, 32'h0, c + 1);
    run_p0(1'b0, 32'h02, 32'h0);
    step();

    // Reset during SERVE of a p0 load: no ack, then p1 alone is served
    p0_we = 1'b0; p0_addr = 32'h10; p0_req = 1'b1;
    step();
    reset = 1'b1;
    p0_req = 1'b0;
    @(negedge clk);
    check("reset_serve_p0_ack", {31'd0, p0_ack}, 32'd0);
    step();
    reset = 1'b0;
    c = cyc;
    expect_ack(1'b1, 1'b0, 32'h1415_1617, c + 1);
    run_p1(1'b0, 32'h14, 32'h0);

    repeat (4) step();
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
